syn_pcm_rd_sched: RTL and testbench
===================================

Name: syn_pcm_rd_sched

Overview:
Read scheduler between the acortex PCM buffers (left/right channel mem slaves) and the fgyrus FFT front end, in the fgyrus clock domain. On each one-hot half-buffer-ready indication it sequences reads of that half from both channel memories in lock-step. Returned L/R pairs go into a small FIFO and are presented to fgyrus as a valid/ready sample stream with start/end-of-frame markers. Issue is credit-gated so the FIFO never overflows, whatever the memory read latency.

Parameters:
PCM_MEM_DATA_W, 32, width of one PCM sample word per channel
PCM_MEM_ADDR_W, 7, PCM buffer address width; each half is 2**(PCM_MEM_ADDR_W-1) words
FIFO_DEPTH, 4, pair FIFO depth (power of 2, >=2); also the read credit limit

Ports:
clk_ir  in  1  fgyrus clock (sys_clk_100)
rst_il  in  1  synchronous active-low reset
pcm_data_rdy_oh  in  2  one-cycle pulse per bit; bit0 = lower half ready, bit1 = upper half ready
pcm_addr  out  PCM_MEM_ADDR_W  shared read address to both channel mems
pcm_rden  out  1  shared read enable, one word per cycle
lpcm_rdata  in  PCM_MEM_DATA_W  left read data
rpcm_rdata  in  PCM_MEM_DATA_W  right read data
lpcm_rd_valid  in  1  left read data valid
rpcm_rd_valid  in  1  right read data valid
smpl_valid  out  1  output pair valid
smpl_ready  in  1  fgyrus accepts the pair
smpl_lchnnl  out  PCM_MEM_DATA_W  left sample
smpl_rchnnl  out  PCM_MEM_DATA_W  right sample
smpl_sof  out  1  first pair of a half
smpl_eof  out  1  last pair of a half
frm_done  out  1  one-cycle pulse when the last read of a half has returned
ovrflw_err  out  1  sticky; a half was signalled ready while still pending or being read
sync_err  out  1  sticky; l/r rd_valid mismatch

Behaviour:
- Reset (rst_il=0 at clk edge): all outputs 0. State IDLE. Pending flags, counters and FIFO cleared. Reset mid-frame abandons the frame. Late rd_valid after reset is ignored, because outstanding is 0 and the FIFO is empty.
- Pending flags pend[1:0]: set by pcm_data_rdy_oh[i] and cleared when half i is accepted into RD. If rdy arrives for a half already pending or currently in RD, set ovrflw_err; pend stays 1 (no double queueing).
- FSM IDLE -> RD when any pend is set.
  - Selection: if both are set, take the opposite of the last-served half (ping-pong); after reset, take half 0.
  - Capture cur_half. Set rd_cnt=0.
- RD: issue when credit>0. Issue means pcm_rden=1 and pcm_addr={cur_half, rd_cnt}; rd_cnt++.
  - Credit = FIFO_DEPTH - fifo_count - outstanding.
  - Outstanding is incremented on issue, decremented on accepted return, and unchanged when both happen in one cycle.
  - After the issue with rd_cnt = half_size-1, go to DRAIN.
- DRAIN: when outstanding==0, pulse frm_done, then IDLE. A new half may then start the next cycle. Read issue is never overlapped across halves.
- Returns: the pair {lpcm_rdata, rpcm_rdata} is pushed when lpcm_rd_valid & rpcm_rd_valid.
  - If exactly one valid is high: set sync_err, push nothing, decrement outstanding (the word is dropped).
- Per-entry sof/eof tags are computed from a return counter: sof at return 0, eof at return half_size-1.
- FIFO: first-word-fall-through. smpl_valid = !empty; output fields come from the head entry. Pop on smpl_valid & smpl_ready. Push and pop in the same cycle when full is legal. Push when full is unreachable by construction (credit); assert it in simulation.
- Address increments within the half only; there is no wrap into the other half.
- rdy pulses during reset are ignored.

Decomposition:
- syn_fgyrus_pkg: pcm_pair_t struct {lchnnl, rchnnl, sof, eof}, pcm_rd_sched_st_t enum {IDLE, RD, DRAIN}, localparam HALF_SIZE function of PCM_MEM_ADDR_W.
- Sub-module syn_pcm_pair_fifo: sync FWFT FIFO of pcm_pair_t, FIFO_DEPTH deep, with count output.
- The scheduler holds the FSM, the pend, credit, rd_cnt and return-counter logic, and the error flags.

Test Plan:
- Single half, 2-cycle fixed read latency, smpl_ready=1 -> addresses 0..63 issued on consecutive cycles; 64 pairs out in order; sof on pair 0, eof on pair 63; one frm_done pulse.
- smpl_ready held 0 after rdy bit1 -> exactly FIFO_DEPTH=4 reads issued (addr 64..67), then rden stays 0. Release ready -> remaining 60 read and delivered intact, 64 total.
- rdy=2'b11 in the same cycle after reset -> half 0 (addr 0..63) fully read, then half 1 (addr 64..127); two frm_done pulses; no ovrflw_err.
- Second rdy bit0 while half 0 is in RD -> ovrflw_err=1 and sticky; half 0 re-read once after the current frame.
- Force rpcm_rd_valid low for one return -> sync_err=1, 63 pairs out; FSM reaches IDLE via frm_done; no hang.
- Assert rst_il=0 mid-frame for one cycle -> all outputs 0 next cycle; FIFO empty; new rdy starts cleanly at addr 0.

Source files
------------

// File: rtl/syn_fgyrus_pkg.sv
// Shared types for the fgyrus PCM front end: sample-pair record, read
// scheduler states and PCM buffer geometry.
package syn_fgyrus_pkg;

  localparam int unsigned PCM_DATA_W = 32;
  localparam int unsigned PCM_ADDR_W = 7;

  function automatic int unsigned half_size(input int unsigned addr_w);
    return 32'd1 << (addr_w - 1);
  endfunction

  localparam int unsigned HALF_SIZE = half_size(PCM_ADDR_W);

  typedef struct packed {
    logic [PCM_DATA_W-1:0] lchnnl;
    logic [PCM_DATA_W-1:0] rchnnl;
    logic                  sof;
    logic                  eof;
  } pcm_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2
  } pcm_rd_sched_st_t;

endpackage

// File: rtl/syn_pcm_pair_fifo.sv
// Synchronous first-word-fall-through FIFO of L/R sample pairs with an
// occupancy count for the scheduler's credit logic.
module syn_pcm_pair_fifo
  import syn_fgyrus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         push,
  input  pcm_pair_t                    wr_data,
  input  logic                         pop,
  output pcm_pair_t                    rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pcm_pair_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Upstream credit gating must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (rst_l) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/syn_pcm_rd_sched.sv
// Reads ready PCM half-buffers from both channel memories in lock-step and
// streams the returned L/R pairs to fgyrus with frame markers.
module syn_pcm_rd_sched
  import syn_fgyrus_pkg::*;
#(
  parameter int unsigned PCM_MEM_DATA_W = 32,
  parameter int unsigned PCM_MEM_ADDR_W = 7,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_ir,
  input  logic                      rst_il,
  input  logic [1:0]                pcm_data_rdy_oh,
  output logic [PCM_MEM_ADDR_W-1:0] pcm_addr,
  output logic                      pcm_rden,
  input  logic [PCM_MEM_DATA_W-1:0] lpcm_rdata,
  input  logic [PCM_MEM_DATA_W-1:0] rpcm_rdata,
  input  logic                      lpcm_rd_valid,
  input  logic                      rpcm_rd_valid,
  output logic                      smpl_valid,
  input  logic                      smpl_ready,
  output logic [PCM_MEM_DATA_W-1:0] smpl_lchnnl,
  output logic [PCM_MEM_DATA_W-1:0] smpl_rchnnl,
  output logic                      smpl_sof,
  output logic                      smpl_eof,
  output logic                      frm_done,
  output logic                      ovrflw_err,
  output logic                      sync_err
);

  localparam int unsigned CNT_W = PCM_MEM_ADDR_W - 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(half_size(PCM_MEM_ADDR_W) - 1);

  pcm_rd_sched_st_t state;
  logic [1:0]       pend;
  logic [1:0]       pend_nxt;
  logic [1:0]       acc_mask;
  logic [1:0]       in_rd;
  logic             cur_half;
  logic             last_half;
  logic             sel_half;
  logic             accept;
  logic             ovr;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    fifo_count;
  logic [OCC_W-1:0] occ;
  logic             issue;
  logic             ret_any;
  logic             ret_pair;
  logic             ret_bad;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  pcm_pair_t        push_pair;
  pcm_pair_t        head_pair;

  // Both halves pending: alternate away from the last one served.
  assign sel_half = (pend == 2'b11) ? ~last_half : pend[1];
  assign accept   = (state == IDLE) && (pend != 2'b00);
  assign acc_mask = accept ? (sel_half ? 2'b10 : 2'b01) : 2'b00;
  assign in_rd    = (state == RD) ? (cur_half ? 2'b10 : 2'b01) : 2'b00;
  assign ovr      = |(pcm_data_rdy_oh & (pend | in_rd));
  assign pend_nxt = (pend & ~acc_mask) | pcm_data_rdy_oh;

  assign occ   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign issue = (state == RD) && (occ < OCC_W'(FIFO_DEPTH));

  // Returns with nothing outstanding are stale (e.g. across a reset).
  assign ret_any  = (lpcm_rd_valid | rpcm_rd_valid) && (outstanding != '0);
  assign ret_pair = lpcm_rd_valid && rpcm_rd_valid && (outstanding != '0);
  assign ret_bad  = ret_any && !ret_pair;

  assign push_pair.lchnnl = lpcm_rdata;
  assign push_pair.rchnnl = rpcm_rdata;
  assign push_pair.sof    = (ret_cnt == '0);
  assign push_pair.eof    = (ret_cnt == CNT_LAST);

  assign pcm_rden = issue;
  assign pcm_addr = {cur_half, rd_cnt};
  assign frm_done = (state == DRAIN) && (outstanding == '0);

  assign smpl_valid  = ~fifo_empty;
  assign fifo_pop    = smpl_ready & ~fifo_empty;
  assign smpl_lchnnl = fifo_empty ? '0 : head_pair.lchnnl;
  assign smpl_rchnnl = fifo_empty ? '0 : head_pair.rchnnl;
  assign smpl_sof    = ~fifo_empty & head_pair.sof;
  assign smpl_eof    = ~fifo_empty & head_pair.eof;

  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      state       <= IDLE;
      pend        <= '0;
      cur_half    <= 1'b0;
      last_half   <= 1'b1;
      rd_cnt      <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      ovrflw_err  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (ovr)     ovrflw_err <= 1'b1;
      if (ret_bad) sync_err   <= 1'b1;
      if (ret_any) ret_cnt    <= ret_cnt + CNT_W'(1);
      case ({issue, ret_any})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RD;
            cur_half  <= sel_half;
            last_half <= sel_half;
            rd_cnt    <= '0;
            ret_cnt   <= '0;
          end
        end
        RD: begin
          if (issue) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt == CNT_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  syn_pcm_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk     (clk_ir),
    .rst_l   (rst_il),
    .push    (ret_pair),
    .wr_data (push_pair),
    .pop     (fifo_pop),
    .rd_data (head_pair),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_syn_pcm_rd_sched.sv
// Directed bench for syn_pcm_rd_sched: 2-cycle memory model, expected
// address/pair queues and a per-cycle credit bound.
module tb_syn_pcm_rd_sched;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int HALF  = 64;

  logic          clk_ir = 1'b0;
  logic          rst_il;
  logic [1:0]    pcm_data_rdy_oh;
  logic [AW-1:0] pcm_addr;
  logic          pcm_rden;
  logic [DW-1:0] lpcm_rdata;
  logic [DW-1:0] rpcm_rdata;
  logic          lpcm_rd_valid;
  logic          rpcm_rd_valid;
  logic          smpl_valid;
  logic          smpl_ready;
  logic [DW-1:0] smpl_lchnnl;
  logic [DW-1:0] smpl_rchnnl;
  logic          smpl_sof;
  logic          smpl_eof;
  logic          frm_done;
  logic          ovrflw_err;
  logic          sync_err;

  always #5 clk_ir = ~clk_ir;

  syn_pcm_rd_sched #(
    .PCM_MEM_DATA_W (DW),
    .PCM_MEM_ADDR_W (AW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_ir          (clk_ir),
    .rst_il          (rst_il),
    .pcm_data_rdy_oh (pcm_data_rdy_oh),
    .pcm_addr        (pcm_addr),
    .pcm_rden        (pcm_rden),
    .lpcm_rdata      (lpcm_rdata),
    .rpcm_rdata      (rpcm_rdata),
    .lpcm_rd_valid   (lpcm_rd_valid),
    .rpcm_rd_valid   (rpcm_rd_valid),
    .smpl_valid      (smpl_valid),
    .smpl_ready      (smpl_ready),
    .smpl_lchnnl     (smpl_lchnnl),
    .smpl_rchnnl     (smpl_rchnnl),
    .smpl_sof        (smpl_sof),
    .smpl_eof        (smpl_eof),
    .frm_done        (frm_done),
    .ovrflw_err      (ovrflw_err),
    .sync_err        (sync_err)
  );

  function automatic logic [DW-1:0] lw(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  function automatic logic [DW-1:0] rw(input logic [AW-1:0] a);
    return 32'h5A5A_0000 + 32'(a) * 2;
  endfunction

  // Channel memories: fixed 2-cycle read latency, optional right-side drop.
  logic [1:0]    pv = 2'b00;
  logic [AW-1:0] pa0 = '0;
  logic [AW-1:0] pa1 = '0;
  int            drop_addr = -1;

  always @(posedge clk_ir) begin
    pv  <= {pv[0], pcm_rden};
    pa0 <= pcm_addr;
    pa1 <= pa0;
  end

  assign lpcm_rd_valid = pv[1];
  assign rpcm_rd_valid = pv[1] && (int'(pa1) != drop_addr);
  assign lpcm_rdata    = lw(pa1);
  assign rpcm_rdata    = rw(pa1);

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          sof;
    logic          eof;
  } exp_t;

  int   exp_addr_q[$];
  exp_t exp_pair_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int issued = 0;
  int popped = 0;
  int dropped = 0;
  int frm_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_half(input int h, input int drop_idx);
    exp_t e;
    for (int i = 0; i < HALF; i++) begin
      exp_addr_q.push_back(h * HALF + i);
      if (i != drop_idx) begin
        e.l   = lw(AW'(h * HALF + i));
        e.r   = rw(AW'(h * HALF + i));
        e.sof = (i == 0);
        e.eof = (i == HALF - 1);
        exp_pair_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_rdy(input logic [1:0] v);
    @(posedge clk_ir);
    #1 pcm_data_rdy_oh = v;
    @(posedge clk_ir);
    #1 pcm_data_rdy_oh = 2'b00;
  endtask

  task automatic wait_done(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ir);
      #1;
      if (frm_cnt >= target && exp_addr_q.size() == 0 &&
          exp_pair_q.size() == 0 && !smpl_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_complete", 64'(ok), 64'd1);
  endtask

  // Per-cycle comparison against the expected address/pair streams.
  always @(negedge clk_ir) begin
    int   occ;
    exp_t e;
    if (chk_en) begin
      occ = issued - popped - dropped;
      if (pcm_rden) begin
        check("credit_bound", 64'(occ < DEPTH), 64'd1);
        if (exp_addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rden_unexpected: got addr %0d, expected no read", pcm_addr);
        end else begin
          check("rd_addr", 64'(pcm_addr), 64'(exp_addr_q.pop_front()));
        end
        issued++;
      end
      if (lpcm_rd_valid != rpcm_rd_valid) dropped++;
      if (smpl_valid && smpl_ready) begin
        if (exp_pair_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pair_unexpected: got l=%0h r=%0h, expected none", smpl_lchnnl, smpl_rchnnl);
        end else begin
          e = exp_pair_q.pop_front();
          check("smpl_lchnnl", 64'(smpl_lchnnl), 64'(e.l));
          check("smpl_rchnnl", 64'(smpl_rchnnl), 64'(e.r));
          check("smpl_sof", 64'(smpl_sof), 64'(e.sof));
          check("smpl_eof", 64'(smpl_eof), 64'(e.eof));
        end
        popped++;
      end
      if (frm_done) frm_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int f0;
    int p0;
    int i0;
    rst_il          = 1'b0;
    pcm_data_rdy_oh = 2'b00;
    smpl_ready      = 1'b0;
    repeat (3) @(posedge clk_ir);
    @(negedge clk_ir);
    check("reset_ctrl", 64'({pcm_addr, pcm_rden, smpl_valid, smpl_sof, smpl_eof,
                             frm_done, ovrflw_err, sync_err}), 64'd0);
    check("reset_data", {smpl_lchnnl, smpl_rchnnl}, 64'd0);
    @(posedge clk_ir);
    #1 rst_il = 1'b1;
    chk_en = 1'b1;

    // Single half, ready always high
    smpl_ready = 1'b1;
    f0 = frm_cnt; p0 = popped;
    expect_half(0, -1);
    pulse_rdy(2'b01);
    wait_done(f0 + 1, 1000);
    check("t1_frames", 64'(frm_cnt - f0), 64'd1);
    check("t1_pairs", 64'(popped - p0), 64'd64);

    // Back-pressure: only FIFO_DEPTH reads may be issued
    smpl_ready = 1'b0;
    f0 = frm_cnt; p0 = popped; i0 = issued;
    expect_half(1, -1);
    pulse_rdy(2'b10);
    repeat (30) @(posedge clk_ir);
    #1;
    check("t2_stalled_issues", 64'(issued - i0), 64'd4);
    check("t2_head_valid", 64'(smpl_valid), 64'd1);
    check("t2_head_l", 64'(smpl_lchnnl), 64'h0000_0000_A5A5_0040);
    check("t2_head_r", 64'(smpl_rchnnl), 64'h0000_0000_5A5A_0080);
    check("t2_head_sof", 64'(smpl_sof), 64'd1);
    smpl_ready = 1'b1;
    wait_done(f0 + 1, 1000);
    check("t2_pairs", 64'(popped - p0), 64'd64);

    // Both halves ready together: lower first, then upper
    f0 = frm_cnt;
    expect_half(0, -1);
    expect_half(1, -1);
    pulse_rdy(2'b11);
    wait_done(f0 + 2, 2000);
    check("t3_frames", 64'(frm_cnt - f0), 64'd2);
    check("t3_ovrflw", 64'(ovrflw_err), 64'd0);

    // Re-signal half 0 while it is being read
    f0 = frm_cnt;
    expect_half(0, -1);
    expect_half(0, -1);
    pulse_rdy(2'b01);
    repeat (10) @(posedge clk_ir);
    pulse_rdy(2'b01);
    check("t4_ovrflw_set", 64'(ovrflw_err), 64'd1);
    wait_done(f0 + 2, 2000);
    check("t4_frames", 64'(frm_cnt - f0), 64'd2);
    check("t4_ovrflw_sticky", 64'(ovrflw_err), 64'd1);

    // Reset in the middle of a frame
    chk_en = 1'b0;
    pulse_rdy(2'b01);
    repeat (15) @(posedge clk_ir);
    #1 rst_il = 1'b0;
    @(posedge clk_ir);
    #1 rst_il = 1'b1;
    check("t6_reset_ctrl", 64'({pcm_addr, pcm_rden, smpl_valid, smpl_sof, smpl_eof,
                                frm_done, ovrflw_err, sync_err}), 64'd0);
    check("t6_reset_data", {smpl_lchnnl, smpl_rchnnl}, 64'd0);
    exp_addr_q.delete();
    exp_pair_q.delete();
    issued = 0; popped = 0; dropped = 0;
    repeat (5) @(posedge clk_ir);
    #1;
    check("t6_quiet", 64'({smpl_valid, pcm_rden}), 64'd0);
    chk_en = 1'b1;
    f0 = frm_cnt;
    expect_half(0, -1);
    pulse_rdy(2'b01);
    wait_done(f0 + 1, 1000);
    check("t6_frames", 64'(frm_cnt - f0), 64'd1);

    // Right channel misses one return
    f0 = frm_cnt; p0 = popped;
    drop_addr = 74;
    expect_half(1, 10);
    pulse_rdy(2'b10);
    wait_done(f0 + 1, 1000);
    drop_addr = -1;
    check("t5_sync_err", 64'(sync_err), 64'd1);
    check("t5_pairs", 64'(popped - p0), 64'd63);
    check("t5_frames", 64'(frm_cnt - f0), 64'd1);
    check("t5_ovrflw", 64'(ovrflw_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
